// File: rtl/fb_pattern_writer_if.sv
// Wishbone classic write-master bundle between the frame-buffer pattern writer and the SDRAM controller.
interface fb_pattern_writer_if;
  logic [31:0] adr;
  logic [31:0] dat_ms;
  logic        we;
  logic        cyc;
  logic        stb;
  logic [3:0]  sel;
  logic [2:0]  cti;
  logic [1:0]  bte;
  logic        ack;

  modport master (
    output adr, dat_ms, we, cyc, stb, sel, cti, bte,
    input  ack
  );

  modport slave (
    input  adr, dat_ms, we, cyc, stb, sel, cti, bte,
    output ack
  );
endinterface

// File: rtl/fb_pattern_writer.sv
// Fills a HDISP x VDISP frame buffer with a 16-pixel grid pattern over Wishbone classic single writes.
// Define FB_WRITER_LOOP_EN to refill the frame forever instead of stopping in DONE.
module fb_pattern_writer #(
  parameter int HDISP = 800,
  parameter int VDISP = 480,
  parameter int BURST = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  fb_pattern_writer_if.master   wb,
  output logic                  done
);

  localparam int XW = (HDISP > 1) ? $clog2(HDISP) : 1;
  localparam int YW = (VDISP > 1) ? $clog2(VDISP) : 1;
  localparam int BW = (BURST > 1) ? $clog2(BURST) : 1;

  localparam logic [XW-1:0] X_LAST = XW'(HDISP - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(VDISP - 1);
  localparam logic [BW-1:0] B_LAST = BW'(BURST - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WRITE,
    S_PAUSE,
    S_DONE
  } state_t;

  state_t         state_q;
  logic [XW-1:0]  x_q, x_d;
  logic [YW-1:0]  y_q, y_d;
  logic [BW-1:0]  burst_q;
  logic [31:0]    adr_q;
  logic [31:0]    dat_q;
  logic           cyc_q;
  logic           stb_q;
  logic           done_q;

  logic           ack_ok;
  logic           last_px;
  logic           burst_end;

  // Grid lines every 16 pixels in both directions, white on black.
  function automatic logic [31:0] pattern(input logic [XW-1:0] px, input logic [YW-1:0] py);
    logic [31:0] xx;
    logic [31:0] yy;
    xx = 32'(px);
    yy = 32'(py);
    return ((xx[3:0] == 4'd0) || (yy[3:0] == 4'd0)) ? 32'h00FF_FFFF : 32'h0000_0000;
  endfunction

  always_comb begin
    x_d = x_q + XW'(1);
    y_d = y_q;
    if (x_q == X_LAST) begin
      x_d = '0;
      y_d = y_q + YW'(1);
    end
  end

  assign ack_ok    = wb.ack && stb_q;
  assign last_px   = (x_q == X_LAST) && (y_q == Y_LAST);
  assign burst_end = (burst_q == B_LAST);

  // Address advances by one word per ack, which tracks 4*(y*HDISP+x) in raster order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      burst_q <= '0;
      adr_q   <= '0;
      dat_q   <= '0;
      cyc_q   <= 1'b0;
      stb_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q <= S_WRITE;
            x_q     <= '0;
            y_q     <= '0;
            burst_q <= '0;
            adr_q   <= '0;
            dat_q   <= pattern('0, '0);
            cyc_q   <= 1'b1;
            stb_q   <= 1'b1;
          end
        end

        S_WRITE: begin
          if (ack_ok) begin
            if (last_px) begin
`ifdef FB_WRITER_LOOP_EN
              state_q <= S_PAUSE;
              x_q     <= '0;
              y_q     <= '0;
              burst_q <= '0;
              adr_q   <= '0;
              dat_q   <= pattern('0, '0);
              cyc_q   <= 1'b0;
              stb_q   <= 1'b0;
`else
              state_q <= S_DONE;
              burst_q <= '0;
              cyc_q   <= 1'b0;
              stb_q   <= 1'b0;
              done_q  <= 1'b1;
`endif
            end else begin
              x_q   <= x_d;
              y_q   <= y_d;
              adr_q <= adr_q + 32'd4;
              dat_q <= pattern(x_d, y_d);
              if (burst_end) begin
                // Release the bus for one cycle so the display reader can win arbitration.
                state_q <= S_PAUSE;
                burst_q <= '0;
                cyc_q   <= 1'b0;
                stb_q   <= 1'b0;
              end else begin
                burst_q <= burst_q + BW'(1);
              end
            end
          end
        end

        S_PAUSE: begin
          state_q <= S_WRITE;
          cyc_q   <= 1'b1;
          stb_q   <= 1'b1;
        end

        S_DONE: begin
          done_q <= 1'b1;
        end

        default: begin
          state_q <= S_IDLE;
          cyc_q   <= 1'b0;
          stb_q   <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign wb.adr    = adr_q;
  assign wb.dat_ms = dat_q;
  assign wb.cyc    = cyc_q;
  assign wb.stb    = stb_q;
  assign wb.we     = 1'b1;
  assign wb.sel    = 4'b1111;
  assign wb.cti    = 3'b000;
  assign wb.bte    = 2'b00;
  assign done      = done_q;

endmodule
